// File: rtl/dart_game_multi.sv
// dart_game_multi: parametrised multi-player dart scorer.
//
// Sits between the debounced throw button and the score/display logic.
// A rising edge on throw_button while playing scores one throw for the
// current player; points come from a free-running 5-bit LFSR. After
// THROWS_PER_TURN throws the turn rotates, and after ROUNDS full rotations
// the game ends with the winner and tie flags frozen until restart.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high; restores every register
//   throw_button  debounced level; a throw is its rising edge
//   new_game      synchronous restart, same as reset but the LFSR keeps running
//   player_id     current player, 1-based
//   throw_points  points of the most recent accepted throw
//   throw_valid   one-cycle pulse when throw_points/score update
//   score_display current player's score
//   total_score   saturating sum of all player scores
//   round_num     current round, 1-based
//   game_over     high while in DONE
//   winner_id     lowest-index player holding the max score (valid in DONE)
//   tie           two or more players share the max score (valid in DONE)
//
// FSM states:
//   state | meaning
//   PLAY  | throws accepted, turn/round rotation active
//   DONE  | game finished, throws ignored, winner/tie held

module dart_game_multi #(
  parameter int         NUM_PLAYERS     = 3,
  parameter int         THROWS_PER_TURN = 5,
  parameter int         ROUNDS          = 3,
  parameter int         SCORE_W         = 8,
  parameter logic [4:0] LFSR_SEED       = 5'b10101
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               throw_button,
  input  logic               new_game,
  output logic [2:0]         player_id,
  output logic [2:0]         throw_points,
  output logic               throw_valid,
  output logic [SCORE_W-1:0] score_display,
  output logic [SCORE_W+2:0] total_score,
  output logic [3:0]         round_num,
  output logic               game_over,
  output logic [2:0]         winner_id,
  output logic               tie
);

  typedef enum logic {PLAY, DONE} state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [2:0]         LAST_THROW  = 3'(THROWS_PER_TURN - 1);
  localparam logic [2:0]         LAST_PLAYER = 3'(NUM_PLAYERS);
  localparam logic [3:0]         LAST_ROUND  = 4'(ROUNDS);

  state_t             state;
  logic [4:0]         prbs;
  logic               btn_q;
  logic [2:0]         throw_cnt;
  logic [SCORE_W-1:0] scores [NUM_PLAYERS];

  logic [2:0]         pts;
  logic               accept;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W:0]   cur_sum;
  logic [SCORE_W-1:0] cur_sum_sat;
  logic [SCORE_W-1:0] scores_upd [NUM_PLAYERS];
  logic [SCORE_W-1:0] best;
  logic [2:0]         best_id;
  logic [2:0]         best_cnt;
  logic [SCORE_W+3:0] sum_all;

  always_comb begin
    case (prbs[2:0])
      3'b000:  pts = 3'd5;
      3'b001:  pts = 3'd4;
      3'b010:  pts = 3'd3;
      3'b011:  pts = 3'd2;
      3'b100:  pts = 3'd1;
      default: pts = 3'd0;
    endcase
  end

  assign accept = throw_button && !btn_q && (state == PLAY);

  // Current player's score and its saturated post-throw value.
  always_comb begin
    cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (player_id == 3'(i + 1)) cur_score = scores[i];
    end
    cur_sum     = {1'b0, cur_score} + (SCORE_W + 1)'(pts);
    cur_sum_sat = cur_sum[SCORE_W] ? SCORE_MAX : cur_sum[SCORE_W-1:0];
  end

  assign score_display = cur_score;

  // Winner/tie are judged on the scores including the final throw, since
  // that throw commits on the same edge that enters DONE.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      scores_upd[i] = (player_id == 3'(i + 1)) ? cur_sum_sat : scores[i];
    end
    best    = scores_upd[0];
    best_id = 3'd1;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (scores_upd[i] > best) begin
        best    = scores_upd[i];
        best_id = 3'(i + 1);
      end
    end
    best_cnt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (scores_upd[i] == best) best_cnt = best_cnt + 3'd1;
    end
  end

  // One extra bit of headroom so saturation can be detected.
  always_comb begin
    sum_all = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      sum_all = sum_all + (SCORE_W + 4)'(scores[i]);
    end
    total_score = sum_all[SCORE_W+3] ? '1 : sum_all[SCORE_W+2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prbs         <= LFSR_SEED;
      btn_q        <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) scores[i] <= '0;
      throw_points <= 3'd0;
      throw_valid  <= 1'b0;
      player_id    <= 3'd1;
      round_num    <= 4'd1;
      throw_cnt    <= 3'd0;
      state        <= PLAY;
      game_over    <= 1'b0;
      winner_id    <= 3'd0;
      tie          <= 1'b0;
    end else begin
      prbs        <= {prbs[3:0], prbs[4] ^ prbs[2]};
      btn_q       <= throw_button;
      throw_valid <= 1'b0;
      if (new_game) begin
        for (int i = 0; i < NUM_PLAYERS; i++) scores[i] <= '0;
        throw_points <= 3'd0;
        player_id    <= 3'd1;
        round_num    <= 4'd1;
        throw_cnt    <= 3'd0;
        state        <= PLAY;
        game_over    <= 1'b0;
        winner_id    <= 3'd0;
        tie          <= 1'b0;
      end else if (accept) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (player_id == 3'(i + 1)) scores[i] <= cur_sum_sat;
        end
        throw_points <= pts;
        throw_valid  <= 1'b1;
        if (throw_cnt == LAST_THROW) begin
          throw_cnt <= 3'd0;
          if (player_id == LAST_PLAYER) begin
            if (round_num == LAST_ROUND) begin
              // Final position stays on the last player/round.
              state     <= DONE;
              game_over <= 1'b1;
              winner_id <= best_id;
              tie       <= (best_cnt > 3'd1);
            end else begin
              player_id <= 3'd1;
              round_num <= round_num + 4'd1;
            end
          end else begin
            player_id <= player_id + 3'd1;
          end
        end else begin
          throw_cnt <= throw_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dart_game_multi.sv
// Directed bench for dart_game_multi: default 3-player instance plus a
// 2-player, 3-bit-score instance for saturation.

module tb_dart_game_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       throw_button = 1'b0;
  logic       throw_button2 = 1'b0;

  logic [2:0]  player_id, throw_points, winner_id;
  logic        throw_valid, game_over, tie;
  logic [7:0]  score_display;
  logic [10:0] total_score;
  logic [3:0]  round_num;

  logic [2:0]  player_id2, throw_points2, winner_id2;
  logic        throw_valid2, game_over2, tie2;
  logic [2:0]  score_display2;
  logic [5:0]  total_score2;
  logic [3:0]  round_num2;

  dart_game_multi dut (
    .clk(clk), .reset(reset), .throw_button(throw_button), .new_game(new_game),
    .player_id(player_id), .throw_points(throw_points), .throw_valid(throw_valid),
    .score_display(score_display), .total_score(total_score), .round_num(round_num),
    .game_over(game_over), .winner_id(winner_id), .tie(tie)
  );

  dart_game_multi #(.NUM_PLAYERS(2), .THROWS_PER_TURN(7), .ROUNDS(1), .SCORE_W(3)) dut2 (
    .clk(clk), .reset(reset), .throw_button(throw_button2), .new_game(new_game),
    .player_id(player_id2), .throw_points(throw_points2), .throw_valid(throw_valid2),
    .score_display(score_display2), .total_score(total_score2), .round_num(round_num2),
    .game_over(game_over2), .winner_id(winner_id2), .tie(tie2)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model of the default instance.
  logic [4:0] m_prbs;
  int  m_score [3];
  int  m_player, m_round, m_cnt, m_win;
  bit  m_over, m_tie;

  always @(posedge clk) m_prbs <= reset ? 5'b10101 : {m_prbs[3:0], m_prbs[4] ^ m_prbs[2]};

  function automatic int pmap(input logic [2:0] b);
    case (b)
      3'b000:  return 5;
      3'b001:  return 4;
      3'b010:  return 3;
      3'b011:  return 2;
      3'b100:  return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_score[i] = 0;
    m_player = 1; m_round = 1; m_cnt = 0; m_over = 0; m_win = 0; m_tie = 0;
  endtask

  task automatic model_accept(input int p);
    int best, cnt;
    if (m_over) return;
    m_score[m_player-1] = (m_score[m_player-1] + p > 255) ? 255 : m_score[m_player-1] + p;
    if (m_cnt == 4) begin
      m_cnt = 0;
      if (m_player == 3) begin
        if (m_round == 3) begin
          m_over = 1;
          best = m_score[0]; m_win = 1;
          for (int i = 1; i < 3; i++) if (m_score[i] > best) begin best = m_score[i]; m_win = i + 1; end
          cnt = 0;
          for (int i = 0; i < 3; i++) if (m_score[i] == best) cnt++;
          m_tie = (cnt > 1);
        end else begin
          m_player = 1; m_round++;
        end
      end else m_player++;
    end else m_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; new_game = 1'b0; throw_button = 1'b0; throw_button2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One rising edge on the default instance; want >= 0 waits for an LFSR
  // state giving that many points. Returns observed and expected values.
  task automatic do_throw(input int want, output logic tv, output logic [2:0] tp,
                          output bit exp_tv, output int exp_pts);
    int tries = 0;
    @(negedge clk);
    while (want >= 0 && pmap(m_prbs[2:0]) != want && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL wait_points: no %0d-point state within 100 cycles", want);
    end
    exp_pts = pmap(m_prbs[2:0]);
    throw_button = 1'b1;
    @(posedge clk); #1;
    tv = throw_valid; tp = throw_points;
    exp_tv = !m_over;
    if (exp_tv) model_accept(exp_pts);
    @(negedge clk);
    throw_button = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (player_id !== 3'd1) begin n_fail++; $display("FAIL reset_player got %0d exp 1", player_id); end
    n_checks++; if (round_num !== 4'd1) begin n_fail++; $display("FAIL reset_round got %0d exp 1", round_num); end
    n_checks++; if (score_display !== 8'd0) begin n_fail++; $display("FAIL reset_score got %0d exp 0", score_display); end
    n_checks++; if (total_score !== 11'd0) begin n_fail++; $display("FAIL reset_total got %0d exp 0", total_score); end
    n_checks++; if (throw_points !== 3'd0) begin n_fail++; $display("FAIL reset_points got %0d exp 0", throw_points); end
    n_checks++; if ({throw_valid, game_over, tie} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {throw_valid, game_over, tie}); end
    n_checks++; if (winner_id !== 3'd0) begin n_fail++; $display("FAIL reset_winner got %0d exp 0", winner_id); end
    n_checks++; if (dut.prbs !== 5'b10101) begin n_fail++; $display("FAIL reset_prbs got %b exp 10101", dut.prbs); end
    n_checks++; if ({player_id2, score_display2, total_score2} !== {3'd1, 3'd0, 6'd0}) begin n_fail++; $display("FAIL reset_dut2 got %0d/%0d/%0d exp 1/0/0", player_id2, score_display2, total_score2); end
  endtask

  task automatic test_first_throws();
    logic [2:0] exp_tp [4];
    exp_tp = '{3'd0, 3'd3, 3'd1, 3'd5};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      repeat (k) @(negedge clk);
      throw_button = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (throw_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid[%0d] got %b exp 1", k, throw_valid); end
      n_checks++; if (throw_points !== exp_tp[k]) begin n_fail++; $display("FAIL first_points[%0d] got %0d exp %0d", k, throw_points, exp_tp[k]); end
      @(negedge clk);
      throw_button = 1'b0;
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    int exp_p;
    logic [2:0] seen = 3'd7;
    logic tv; logic [2:0] tp; bit etv; int ep;
    do_reset();
    @(negedge clk);
    exp_p = pmap(m_prbs[2:0]);
    throw_button = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (throw_valid === 1'b1) begin pulses++; seen = throw_points; end
    end
    model_accept(exp_p);
    @(negedge clk);
    throw_button = 1'b0;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    n_checks++; if (seen !== 3'(exp_p)) begin n_fail++; $display("FAIL hold_points got %0d exp %0d", seen, exp_p); end
    for (int i = 0; i < 4; i++) begin
      do_throw(-1, tv, tp, etv, ep);
      n_checks++; if (player_id !== 3'(m_player)) begin n_fail++; $display("FAIL hold_player[%0d] got %0d exp %0d", i, player_id, m_player); end
    end
    n_checks++; if (player_id !== 3'd2) begin n_fail++; $display("FAIL hold_turn_pass got %0d exp 2", player_id); end
    n_checks++; if (total_score !== 11'(m_score[0])) begin n_fail++; $display("FAIL hold_total got %0d exp %0d", total_score, m_score[0]); end
  endtask

  task automatic test_rotation();
    logic tv; logic [2:0] tp; bit etv; int ep;
    for (int i = 0; i < 10; i++) begin
      do_throw(-1, tv, tp, etv, ep);
      n_checks++; if (tv !== 1'b1 || tp !== 3'(ep)) begin n_fail++; $display("FAIL rot_throw[%0d] got %b/%0d exp 1/%0d", i, tv, tp, ep); end
      n_checks++; if (score_display !== 8'(m_score[m_player-1])) begin n_fail++; $display("FAIL rot_score[%0d] got %0d exp %0d", i, score_display, m_score[m_player-1]); end
      n_checks++; if (player_id !== 3'(m_player) || round_num !== 4'(m_round)) begin n_fail++; $display("FAIL rot_pos[%0d] got %0d/%0d exp %0d/%0d", i, player_id, round_num, m_player, m_round); end
    end
    n_checks++; if (player_id !== 3'd1 || round_num !== 4'd2) begin n_fail++; $display("FAIL rot_wrap got %0d/%0d exp 1/2", player_id, round_num); end
  endtask

  task automatic test_game_over();
    logic tv; logic [2:0] tp; bit etv; int ep;
    for (int i = 0; i < 30; i++) begin
      do_throw(-1, tv, tp, etv, ep);
      n_checks++; if (tv !== 1'b1 || tp !== 3'(ep)) begin n_fail++; $display("FAIL go_throw[%0d] got %b/%0d exp 1/%0d", i, tv, tp, ep); end
      n_checks++; if (total_score !== 11'(m_score[0] + m_score[1] + m_score[2])) begin n_fail++; $display("FAIL go_total[%0d] got %0d exp %0d", i, total_score, m_score[0] + m_score[1] + m_score[2]); end
    end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL go_flag got %b exp 1", game_over); end
    n_checks++; if (player_id !== 3'd3 || round_num !== 4'd3) begin n_fail++; $display("FAIL go_pos got %0d/%0d exp 3/3", player_id, round_num); end
    n_checks++; if (winner_id !== 3'(m_win) || tie !== m_tie) begin n_fail++; $display("FAIL go_winner got %0d/%b exp %0d/%b", winner_id, tie, m_win, m_tie); end
    for (int i = 0; i < 3; i++) begin
      do_throw(-1, tv, tp, etv, ep);
      n_checks++; if (tv !== 1'b0) begin n_fail++; $display("FAIL go_ignored[%0d] got %b exp 0", i, tv); end
    end
    n_checks++; if (game_over !== 1'b1 || winner_id !== 3'(m_win)) begin n_fail++; $display("FAIL go_held got %b/%0d exp 1/%0d", game_over, winner_id, m_win); end
    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({game_over, tie, winner_id} !== 5'b00000) begin n_fail++; $display("FAIL go_restart got %b exp 00000", {game_over, tie, winner_id}); end
    n_checks++; if (total_score !== 11'd0 || player_id !== 3'd1) begin n_fail++; $display("FAIL go_restart_state got %0d/%0d exp 0/1", total_score, player_id); end
    model_clear();
    @(negedge clk); new_game = 1'b0;
    for (int i = 0; i < 45; i++) begin
      do_throw(0, tv, tp, etv, ep);
      n_checks++; if (tv !== 1'b1 || tp !== 3'd0) begin n_fail++; $display("FAIL zero_throw[%0d] got %b/%0d exp 1/0", i, tv, tp); end
    end
    n_checks++; if (game_over !== 1'b1 || tie !== 1'b1 || winner_id !== 3'd1) begin n_fail++; $display("FAIL zero_result got %b/%b/%0d exp 1/1/1", game_over, tie, winner_id); end
    n_checks++; if (total_score !== 11'd0) begin n_fail++; $display("FAIL zero_total got %0d exp 0", total_score); end
  endtask

  task automatic test_new_game();
    logic tv; logic [2:0] tp; bit etv; int ep;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_throw(-1, tv, tp, etv, ep);
      n_checks++; if (tv !== 1'b1 || tp !== 3'(ep)) begin n_fail++; $display("FAIL ng_pre[%0d] got %b/%0d exp 1/%0d", i, tv, tp, ep); end
    end
    n_checks++; if (player_id !== 3'd2 || round_num !== 4'd2) begin n_fail++; $display("FAIL ng_pos got %0d/%0d exp 2/2", player_id, round_num); end
    @(negedge clk); new_game = 1'b1; throw_button = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (throw_valid !== 1'b0) begin n_fail++; $display("FAIL ng_discard got %b exp 0", throw_valid); end
    n_checks++; if (player_id !== 3'd1 || round_num !== 4'd1) begin n_fail++; $display("FAIL ng_pos_clear got %0d/%0d exp 1/1", player_id, round_num); end
    n_checks++; if (score_display !== 8'd0 || total_score !== 11'd0 || throw_points !== 3'd0) begin n_fail++; $display("FAIL ng_clear got %0d/%0d/%0d exp 0/0/0", score_display, total_score, throw_points); end
    n_checks++; if (dut.prbs !== m_prbs) begin n_fail++; $display("FAIL ng_prbs got %b exp %b", dut.prbs, m_prbs); end
    model_clear();
    @(negedge clk); new_game = 1'b0; throw_button = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_throw(-1, tv, tp, etv, ep);
      n_checks++; if (tv !== 1'b1 || tp !== 3'(ep)) begin n_fail++; $display("FAIL ng_post[%0d] got %b/%0d exp 1/%0d", i, tv, tp, ep); end
    end
  endtask

  task automatic test_mid_reset();
    logic tv; logic [2:0] tp; bit etv; int ep;
    do_reset();
    for (int i = 0; i < 7; i++) do_throw(-1, tv, tp, etv, ep);
    @(negedge clk); reset = 1'b1; throw_button = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (throw_valid !== 1'b0 || score_display !== 8'd0 || total_score !== 11'd0) begin n_fail++; $display("FAIL mr_clear got %b/%0d/%0d exp 0/0/0", throw_valid, score_display, total_score); end
    n_checks++; if (player_id !== 3'd1) begin n_fail++; $display("FAIL mr_player got %0d exp 1", player_id); end
    @(negedge clk); reset = 1'b0;
    model_clear();
    n_checks++; if (dut.prbs !== 5'b10101) begin n_fail++; $display("FAIL mr_prbs got %b exp 10101", dut.prbs); end
    @(posedge clk); #1;
    n_checks++; if (throw_valid !== 1'b1 || throw_points !== 3'd0) begin n_fail++; $display("FAIL mr_first got %b/%0d exp 1/0", throw_valid, throw_points); end
    model_accept(0);
    @(negedge clk); throw_button = 1'b0;
    @(negedge clk); throw_button = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (throw_valid !== 1'b1 || throw_points !== 3'd1) begin n_fail++; $display("FAIL mr_third got %b/%0d exp 1/1", throw_valid, throw_points); end
    model_accept(1);
    n_checks++; if (score_display !== 8'd1) begin n_fail++; $display("FAIL mr_score got %0d exp 1", score_display); end
    @(negedge clk); throw_button = 1'b0;
  endtask

  task automatic test_saturate();
    logic [2:0] exp_s [4];
    int tries;
    exp_s = '{3'd5, 3'd7, 3'd7, 3'd7};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tries = 0;
      @(negedge clk);
      while (pmap(m_prbs[2:0]) != 5 && tries < 100) begin @(negedge clk); tries++; end
      if (tries >= 100) begin n_checks++; n_fail++; $display("FAIL sat_wait: no 5-point state within 100 cycles"); end
      throw_button2 = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (throw_valid2 !== 1'b1 || throw_points2 !== 3'd5) begin n_fail++; $display("FAIL sat_throw[%0d] got %b/%0d exp 1/5", i, throw_valid2, throw_points2); end
      n_checks++; if (score_display2 !== exp_s[i]) begin n_fail++; $display("FAIL sat_score[%0d] got %0d exp %0d", i, score_display2, exp_s[i]); end
      n_checks++; if (total_score2 !== 6'(exp_s[i]) || player_id2 !== 3'd1) begin n_fail++; $display("FAIL sat_total[%0d] got %0d/%0d exp %0d/1", i, total_score2, player_id2, exp_s[i]); end
      @(negedge clk); throw_button2 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_first_throws();
    test_hold();
    test_rotation();
    test_game_over();
    test_new_game();
    test_mid_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
